// File: rtl/mesh_router_vc_if.sv
// mesh_router_vc_if: bundles the five-port link signals of the VC mesh router.
//   polarity : phase bit, router -> neighbours (VC = polarity uses the links)
//   in_si    : per-port send request into the router
//   in_di    : per-port input flits, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   in_ri    : per-port ready out of the router
//   out_so   : per-port output valid
//   out_ro   : per-port downstream ready
//   out_do   : per-port output flits, same packing as in_di
// Port index: 0=PE, 1=W, 2=E, 3=N, 4=S.
interface mesh_router_vc_if #(
   parameter int DATA_WIDTH = 64
);
   logic                      polarity;
   logic [4:0]                in_si;
   logic [5*DATA_WIDTH-1:0]   in_di;
   logic [4:0]                in_ri;
   logic [4:0]                out_so;
   logic [4:0]                out_ro;
   logic [5*DATA_WIDTH-1:0]   out_do;

   // Neighbour / NIC side
   modport master (
      input  polarity,
      output in_si,
      output in_di,
      input  in_ri,
      input  out_so,
      output out_ro,
      input  out_do
   );

   // Router side
   modport slave (
      output polarity,
      input  in_si,
      input  in_di,
      output in_ri,
      output out_so,
      input  out_ro,
      output out_do
   );
endinterface

// File: rtl/mesh_router_vc.sv
// mesh_router_vc: five-port source-routed mesh router with two virtual channels.
//   clk   : rising-edge clock
//   reset : synchronous, active-low reset
//   bus   : mesh_router_vc_if.slave (polarity, in_si/in_di/in_ri, out_so/out_ro/out_do)
// Each cycle the VC equal to polarity talks to the links (accept and emit),
// while the other VC switches from the input FIFOs into the output registers.
// Header: [W-1]=vc, [W-2]=xdir(1=W), [W-3]=ydir(1=S), then hx, hy, payload.
module mesh_router_vc #(
   parameter int DATA_WIDTH   = 64,
   parameter int BUFFER_DEPTH = 2,
   parameter int HOP_W        = 4
) (
   input  logic            clk,
   input  logic            reset,
   mesh_router_vc_if.slave bus
);
   localparam int NP    = 5;
   localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
   localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);
   localparam int HX_HI = DATA_WIDTH - 4;
   localparam int HY_HI = DATA_WIDTH - 4 - HOP_W;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUFFER_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(BUFFER_DEPTH - 1);

   // X-first output selection for a header
   function automatic logic [2:0] route_of(input logic [DATA_WIDTH-1:0] flit);
      logic [2:0] r;
      if (flit[HX_HI -: HOP_W] != {HOP_W{1'b0}}) begin
         r = flit[DATA_WIDTH-2] ? 3'd1 : 3'd2;
      end else if (flit[HY_HI -: HOP_W] != {HOP_W{1'b0}}) begin
         r = flit[DATA_WIDTH-3] ? 3'd4 : 3'd3;
      end else begin
         r = 3'd0;
      end
      return r;
   endfunction

   // Header with the hop count of the dimension being travelled decremented
   function automatic logic [DATA_WIDTH-1:0] rewrite(input logic [DATA_WIDTH-1:0] flit);
      logic [DATA_WIDTH-1:0] f;
      f = flit;
      if (flit[HX_HI -: HOP_W] != {HOP_W{1'b0}}) begin
         f[HX_HI -: HOP_W] = flit[HX_HI -: HOP_W] - {{(HOP_W-1){1'b0}}, 1'b1};
      end else if (flit[HY_HI -: HOP_W] != {HOP_W{1'b0}}) begin
         f[HY_HI -: HOP_W] = flit[HY_HI -: HOP_W] - {{(HOP_W-1){1'b0}}, 1'b1};
      end else begin
         f = flit;
      end
      return f;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_MAX) ? {PTR_W{1'b0}} : p + {{(PTR_W-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic [2:0] rr_next(input logic [2:0] w);
      return (w == 3'd4) ? 3'd0 : w + 3'd1;
   endfunction

   // Candidate k positions after the round-robin pointer, modulo 5
   function automatic logic [2:0] rr_index(input logic [2:0] ptr, input int k);
      logic [3:0] s;
      s = {1'b0, ptr} + 4'(k);
      if (s >= 4'd5) begin
         s = s - 4'd5;
      end else begin
         s = s;
      end
      return s[2:0];
   endfunction

   logic                    polarity_r;
   logic [DATA_WIDTH-1:0]   mem_r      [NP][2][BUFFER_DEPTH];
   logic [PTR_W-1:0]        wr_ptr_r   [NP][2];
   logic [PTR_W-1:0]        rd_ptr_r   [NP][2];
   logic [CNT_W-1:0]        count_r    [NP][2];
   logic [DATA_WIDTH-1:0]   out_data_r [NP][2];
   logic                    out_full_r [NP][2];
   logic [2:0]              rr_ptr_r   [NP][2];

   logic                    vsw_s;
   logic [NP-1:0]           in_ri_s;
   logic [NP-1:0]           accept_s;
   logic [NP-1:0]           head_valid_s;
   logic [DATA_WIDTH-1:0]   head_next_s [NP];
   logic [2:0]              head_route_s [NP];
   logic [NP-1:0]           load_s;
   logic [2:0]              win_s [NP];
   logic [NP-1:0]           pop_s;

   assign vsw_s        = ~polarity_r;
   assign bus.polarity = polarity_r;
   assign bus.in_ri    = in_ri_s;

   // Link-side view: ready, valid and data of the polarity VC
   always_comb begin
      in_ri_s    = 5'b00000;
      bus.out_so = 5'b00000;
      bus.out_do = {(5*DATA_WIDTH){1'b0}};
      for (int p = 0; p < NP; p++) begin
         in_ri_s[p]    = (count_r[p][polarity_r] != DEPTH_C);
         bus.out_so[p] = out_full_r[p][polarity_r];
         if (out_full_r[p][polarity_r]) begin
            bus.out_do[p*DATA_WIDTH +: DATA_WIDTH] = out_data_r[p][polarity_r];
         end else begin
            bus.out_do[p*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
         end
      end
   end

   // Accept decode and routed view of the switching-VC FIFO heads
   always_comb begin
      accept_s     = 5'b00000;
      head_valid_s = 5'b00000;
      for (int p = 0; p < NP; p++) begin
         // a flit tagged with the wrong VC is silently dropped
         accept_s[p]     = bus.in_si[p] && in_ri_s[p] &&
                           (bus.in_di[p*DATA_WIDTH + DATA_WIDTH - 1] == polarity_r);
         head_valid_s[p] = (count_r[p][vsw_s] != {CNT_W{1'b0}});
         head_next_s[p]  = rewrite(mem_r[p][vsw_s][rd_ptr_r[p][vsw_s]]);
         head_route_s[p] = route_of(mem_r[p][vsw_s][rd_ptr_r[p][vsw_s]]);
      end
   end

   // Round-robin arbitration per output for the switching VC
   always_comb begin
      load_s = 5'b00000;
      for (int o = 0; o < NP; o++) begin
         win_s[o] = 3'd0;
         if (!out_full_r[o][vsw_s]) begin
            for (int k = 0; k < NP; k++) begin
               if (!load_s[o] &&
                   head_valid_s[rr_index(rr_ptr_r[o][vsw_s], k)] &&
                   (head_route_s[rr_index(rr_ptr_r[o][vsw_s], k)] == 3'(o))) begin
                  load_s[o] = 1'b1;
                  win_s[o]  = rr_index(rr_ptr_r[o][vsw_s], k);
               end else begin
                  load_s[o] = load_s[o];
               end
            end
         end else begin
            load_s[o] = 1'b0;
         end
      end
   end

   // Each head has a single route, so it wins at most one output
   always_comb begin
      pop_s = 5'b00000;
      for (int p = 0; p < NP; p++) begin
         for (int o = 0; o < NP; o++) begin
            if (load_s[o] && (win_s[o] == 3'(p))) begin
               pop_s[p] = 1'b1;
            end else begin
               pop_s[p] = pop_s[p];
            end
         end
      end
   end

   // Phase, FIFO, output-register and arbiter-pointer state
   always_ff @(posedge clk) begin
      if (!reset) begin
         polarity_r <= 1'b0;
         for (int p = 0; p < NP; p++) begin
            for (int v = 0; v < 2; v++) begin
               wr_ptr_r[p][v]   <= {PTR_W{1'b0}};
               rd_ptr_r[p][v]   <= {PTR_W{1'b0}};
               count_r[p][v]    <= {CNT_W{1'b0}};
               out_data_r[p][v] <= {DATA_WIDTH{1'b0}};
               out_full_r[p][v] <= 1'b0;
               rr_ptr_r[p][v]   <= 3'd0;
            end
         end
      end else begin
         polarity_r <= ~polarity_r;
         for (int p = 0; p < NP; p++) begin
            // writes hit VC polarity, pops hit VC ~polarity: never the same FIFO
            if (accept_s[p]) begin
               mem_r[p][polarity_r][wr_ptr_r[p][polarity_r]] <= bus.in_di[p*DATA_WIDTH +: DATA_WIDTH];
               wr_ptr_r[p][polarity_r] <= ptr_next(wr_ptr_r[p][polarity_r]);
               count_r[p][polarity_r]  <= count_r[p][polarity_r] + CNT_ONE;
            end
            if (pop_s[p]) begin
               rd_ptr_r[p][vsw_s] <= ptr_next(rd_ptr_r[p][vsw_s]);
               count_r[p][vsw_s]  <= count_r[p][vsw_s] - CNT_ONE;
            end
         end
         for (int o = 0; o < NP; o++) begin
            if (load_s[o]) begin
               out_data_r[o][vsw_s] <= head_next_s[win_s[o]];
               out_full_r[o][vsw_s] <= 1'b1;
               rr_ptr_r[o][vsw_s]   <= rr_next(win_s[o]);
            end
            if (out_full_r[o][polarity_r] && bus.out_ro[o]) begin
               out_full_r[o][polarity_r] <= 1'b0;
            end
         end
      end
   end
endmodule
